// File: rtl/hist_frame_ctrl.sv
// hist_frame_ctrl
//   Collects FRAME_LEN samples per frame from two requesters (A and B) and
//   forwards each accepted sample to a histogram core one cycle later. Once
//   the frame is full the block stops granting (DRAIN) until the core ends
//   its readout with hist_valid & hist_last. Then it reports frame_done,
//   clears the sample count and returns to COLLECT.
//
//   Handshake: a requester holds *_valid (with *_data) until it sees
//   *_ready. A transfer happens in a cycle where valid and ready are both 1.
//   Ready is combinational from valid, the grant conditions, the FSM state
//   and the last grant, and is never high for both requesters at once.
//   hist_we is a one-cycle strobe with no back-pressure. hist_ready is
//   consumed when the grant is made, not when the strobe is issued.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   en                  1 = grants allowed, 0 = pause acceptance
//   a_valid/a_data/a_ready  requester A (16-bit samples)
//   b_valid/b_data/b_ready  requester B (16-bit samples)
//   hist_ready          histogram core can take a write
//   hist_valid/hist_last    histogram core readout bin valid / final bin
//   hist_we/hist_data   write strobe and sample to the histogram core
//   sample_cnt          samples accepted in the current frame
//   busy                1 while in DRAIN (also serves as the state view)
//   frame_done          one-cycle pulse when a frame's readout completes
module hist_frame_ctrl #(
   parameter int FRAME_LEN = 256,
   parameter int CNT_W     = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             a_valid,
   input  logic [15:0]      a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [15:0]      b_data,
   output logic             b_ready,
   input  logic             hist_ready,
   input  logic             hist_valid,
   input  logic             hist_last,
   output logic             hist_we,
   output logic [15:0]      hist_data,
   output logic [CNT_W-1:0] sample_cnt,
   output logic             busy,
   output logic             frame_done
);

   typedef enum logic {
      COLLECT = 1'b0,
      DRAIN   = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   state_t state;
   state_t state_next;
   logic   last_grant;   // 0 = A granted last, 1 = B granted last
   logic   grant_ok;
   logic   drain_done;
   logic   xfer_a;
   logic   xfer_b;

   always_comb begin
      state_next = state;
      grant_ok   = 1'b0;
      a_ready    = 1'b0;
      b_ready    = 1'b0;
      drain_done = 1'b0;
      case (state)
         COLLECT: begin
            grant_ok = en & hist_ready;
            if (grant_ok) begin
               // On a tie the requester that was not served last wins.
               a_ready = a_valid & (~b_valid | last_grant);
               b_ready = b_valid & (~a_valid | ~last_grant);
            end
            if ((a_ready | b_ready) && (sample_cnt == LAST_IDX)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            // hist_last is only meaningful when qualified by hist_valid.
            drain_done = hist_valid & hist_last;
            if (drain_done) begin
               state_next = COLLECT;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   assign xfer_a = a_valid & a_ready;
   assign xfer_b = b_valid & b_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= COLLECT;
         last_grant <= 1'b1;
         sample_cnt <= '0;
         hist_we    <= 1'b0;
         hist_data  <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         busy       <= (state_next == DRAIN);
         frame_done <= drain_done;
         hist_we    <= xfer_a | xfer_b;
         if (xfer_a) begin
            hist_data  <= a_data;
            last_grant <= 1'b0;
         end else if (xfer_b) begin
            hist_data  <= b_data;
            last_grant <= 1'b1;
         end
         if (drain_done) begin
            sample_cnt <= '0;
         end else if (xfer_a | xfer_b) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hist_frame_ctrl.sv
module tb_hist_frame_ctrl;

   localparam int FRAME_LEN = 4;
   localparam int CNT_W     = 3;

   logic             clk;
   logic             reset;
   logic             en;
   logic             a_valid;
   logic [15:0]      a_data;
   logic             a_ready;
   logic             b_valid;
   logic [15:0]      b_data;
   logic             b_ready;
   logic             hist_ready;
   logic             hist_valid;
   logic             hist_last;
   logic             hist_we;
   logic [15:0]      hist_data;
   logic [CNT_W-1:0] sample_cnt;
   logic             busy;
   logic             frame_done;

   int n_pass;
   int n_total;
   logic [15:0] exp_q[$];

   hist_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .en(en),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .hist_ready(hist_ready), .hist_valid(hist_valid), .hist_last(hist_last),
      .hist_we(hist_we), .hist_data(hist_data), .sample_cnt(sample_cnt),
      .busy(busy), .frame_done(frame_done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks: inputs change on the falling edge
   task automatic drive_req(input logic av, input logic [15:0] ad,
                            input logic bv, input logic [15:0] bd);
      @(negedge clk);
      a_valid = av; a_data = ad;
      b_valid = bv; b_data = bd;
      #1;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b0; a_valid = 1'b0; a_data = '0;
      b_valid = 1'b0; b_data = '0; hist_ready = 1'b0;
      hist_valid = 1'b0; hist_last = 1'b0;
      #22;
      n_total++; if (hist_we !== 1'b0) $display("FAIL rst_hist_we got %b want 0", hist_we); else n_pass++;
      n_total++; if (hist_data !== 16'h0) $display("FAIL rst_hist_data got %h want 0000", hist_data); else n_pass++;
      n_total++; if (sample_cnt !== 3'd0) $display("FAIL rst_cnt got %0d want 0", sample_cnt); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
      n_total++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done got %b want 0", frame_done); else n_pass++;
      @(negedge clk);
      reset = 1'b0; en = 1'b1; hist_ready = 1'b1;
   endtask

   // both valid -> A,B,A,B then DRAIN
   task automatic test_round_robin();
      logic [15:0] exp_d;
      for (int i = 0; i < 4; i++) begin
         drive_req(1'b1, 16'hA000 + 16'(i), 1'b1, 16'hB000 + 16'(i));
         n_total++; if (a_ready !== ((i % 2) == 0)) $display("FAIL rr_a_ready[%0d] got %b want %b", i, a_ready, (i % 2) == 0); else n_pass++;
         n_total++; if (b_ready !== ((i % 2) == 1)) $display("FAIL rr_b_ready[%0d] got %b want %b", i, b_ready, (i % 2) == 1); else n_pass++;
         exp_q.push_back(((i % 2) == 0) ? 16'hA000 + 16'(i) : 16'hB000 + 16'(i));
         n_total++; if (hist_we !== 1'b0 && i == 0) $display("FAIL rr_we_early got %b want 0", hist_we); else n_pass++;
         after_edge();
         exp_d = exp_q.pop_front();
         n_total++; if (hist_we !== 1'b1) $display("FAIL rr_hist_we[%0d] got %b want 1", i, hist_we); else n_pass++;
         n_total++; if (hist_data !== exp_d) $display("FAIL rr_hist_data[%0d] got %h want %h", i, hist_data, exp_d); else n_pass++;
         n_total++; if (sample_cnt !== 3'(i + 1)) $display("FAIL rr_cnt[%0d] got %0d want %0d", i, sample_cnt, i + 1); else n_pass++;
         n_total++; if (busy !== (i == 3)) $display("FAIL rr_busy[%0d] got %b want %b", i, busy, i == 3); else n_pass++;
      end
      // in DRAIN: no grants, strobe drops, data holds
      drive_req(1'b1, 16'h5555, 1'b1, 16'h6666);
      n_total++; if ({a_ready, b_ready} !== 2'b00) $display("FAIL drain_readys got %b want 00", {a_ready, b_ready}); else n_pass++;
      after_edge();
      n_total++; if (hist_we !== 1'b0) $display("FAIL drain_we got %b want 0", hist_we); else n_pass++;
      n_total++; if (hist_data !== 16'hB003) $display("FAIL drain_hold_data got %h want b003", hist_data); else n_pass++;
      n_total++; if (sample_cnt !== 3'd4) $display("FAIL drain_cnt got %0d want 4", sample_cnt); else n_pass++;
   endtask

   task automatic test_drain();
      drive_req(1'b0, '0, 1'b0, '0);
      hist_last = 1'b1; hist_valid = 1'b0;
      after_edge();
      n_total++; if (busy !== 1'b1) $display("FAIL lastonly_busy got %b want 1", busy); else n_pass++;
      n_total++; if (frame_done !== 1'b0) $display("FAIL lastonly_done got %b want 0", frame_done); else n_pass++;
      n_total++; if (sample_cnt !== 3'd4) $display("FAIL lastonly_cnt got %0d want 4", sample_cnt); else n_pass++;
      @(negedge clk);
      hist_valid = 1'b1; hist_last = 1'b1;
      after_edge();
      n_total++; if (frame_done !== 1'b1) $display("FAIL done_pulse got %b want 1", frame_done); else n_pass++;
      n_total++; if (sample_cnt !== 3'd0) $display("FAIL done_cnt got %0d want 0", sample_cnt); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL done_busy got %b want 0", busy); else n_pass++;
      // readout strobes in COLLECT are ignored
      after_edge();
      n_total++; if (frame_done !== 1'b0) $display("FAIL done_one_cycle got %b want 0", frame_done); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL collect_ignore_busy got %b want 0", busy); else n_pass++;
      @(negedge clk);
      hist_valid = 1'b0; hist_last = 1'b0;
   endtask

   // last grant was B, so B alone must still be served
   task automatic test_b_only();
      drive_req(1'b0, 16'hDEAD, 1'b1, 16'h1234);
      n_total++; if (b_ready !== 1'b1) $display("FAIL bonly_b_ready got %b want 1", b_ready); else n_pass++;
      n_total++; if (a_ready !== 1'b0) $display("FAIL bonly_a_ready got %b want 0", a_ready); else n_pass++;
      after_edge();
      n_total++; if (hist_we !== 1'b1) $display("FAIL bonly_we got %b want 1", hist_we); else n_pass++;
      n_total++; if (hist_data !== 16'h1234) $display("FAIL bonly_data got %h want 1234", hist_data); else n_pass++;
      n_total++; if (sample_cnt !== 3'd1) $display("FAIL bonly_cnt got %0d want 1", sample_cnt); else n_pass++;
   endtask

   task automatic test_pause();
      drive_req(1'b1, 16'h0A02, 1'b0, '0);
      after_edge();
      n_total++; if (sample_cnt !== 3'd2) $display("FAIL pause_pre_cnt got %0d want 2", sample_cnt); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         drive_req(1'b1, 16'h0A03, 1'b1, 16'h0B03);
         en = 1'b0; #1;
         n_total++; if ({a_ready, b_ready} !== 2'b00) $display("FAIL pause_readys[%0d] got %b want 00", i, {a_ready, b_ready}); else n_pass++;
         after_edge();
         n_total++; if (hist_we !== 1'b0) $display("FAIL pause_we[%0d] got %b want 0", i, hist_we); else n_pass++;
         n_total++; if (sample_cnt !== 3'd2) $display("FAIL pause_cnt[%0d] got %0d want 2", i, sample_cnt); else n_pass++;
      end
      // A went last, so B wins the next tie, then A
      drive_req(1'b1, 16'h0A03, 1'b1, 16'h0B03);
      en = 1'b1; #1;
      n_total++; if ({a_ready, b_ready} !== 2'b01) $display("FAIL resume1 got %b want 01", {a_ready, b_ready}); else n_pass++;
      after_edge();
      n_total++; if (hist_data !== 16'h0B03) $display("FAIL resume1_data got %h want 0b03", hist_data); else n_pass++;
      drive_req(1'b1, 16'h0A04, 1'b1, 16'h0B04);
      n_total++; if ({a_ready, b_ready} !== 2'b10) $display("FAIL resume2 got %b want 10", {a_ready, b_ready}); else n_pass++;
      after_edge();
      n_total++; if (hist_data !== 16'h0A04) $display("FAIL resume2_data got %h want 0a04", hist_data); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL resume_full_busy got %b want 1", busy); else n_pass++;
      drive_req(1'b0, '0, 1'b0, '0);
      hist_valid = 1'b1; hist_last = 1'b1;
      after_edge();
      @(negedge clk);
      hist_valid = 1'b0; hist_last = 1'b0;
   endtask

   task automatic test_hist_ready();
      for (int i = 0; i < 3; i++) begin
         drive_req(1'b1, 16'h7777, 1'b0, '0);
         hist_ready = 1'b0; #1;
         n_total++; if (a_ready !== 1'b0) $display("FAIL hr_stall_a_ready[%0d] got %b want 0", i, a_ready); else n_pass++;
         after_edge();
         n_total++; if (sample_cnt !== 3'd0) $display("FAIL hr_stall_cnt[%0d] got %0d want 0", i, sample_cnt); else n_pass++;
      end
      drive_req(1'b1, 16'h7777, 1'b0, '0);
      hist_ready = 1'b1; #1;
      n_total++; if (a_ready !== 1'b1) $display("FAIL hr_accept got %b want 1", a_ready); else n_pass++;
      after_edge();
      n_total++; if (hist_data !== 16'h7777) $display("FAIL hr_data got %h want 7777", hist_data); else n_pass++;
      n_total++; if (sample_cnt !== 3'd1) $display("FAIL hr_cnt got %0d want 1", sample_cnt); else n_pass++;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         drive_req(1'b1, 16'hC000 + 16'(i), 1'b0, '0);
         after_edge();
      end
      n_total++; if (busy !== 1'b1) $display("FAIL ar_pre_busy got %b want 1", busy); else n_pass++;
      n_total++; if (hist_we !== 1'b1) $display("FAIL ar_pre_we got %b want 1", hist_we); else n_pass++;
      drive_req(1'b0, '0, 1'b0, '0);
      #1 reset = 1'b1;
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL ar_busy got %b want 0", busy); else n_pass++;
      n_total++; if (sample_cnt !== 3'd0) $display("FAIL ar_cnt got %0d want 0", sample_cnt); else n_pass++;
      n_total++; if (hist_we !== 1'b0) $display("FAIL ar_we got %b want 0", hist_we); else n_pass++;
      n_total++; if (hist_data !== 16'h0) $display("FAIL ar_data got %h want 0000", hist_data); else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      drive_req(1'b1, 16'hAAAA, 1'b1, 16'hBBBB);
      n_total++; if ({a_ready, b_ready} !== 2'b10) $display("FAIL ar_first_tie got %b want 10", {a_ready, b_ready}); else n_pass++;
      after_edge();
      n_total++; if (hist_data !== 16'hAAAA) $display("FAIL ar_first_data got %h want aaaa", hist_data); else n_pass++;
      n_total++; if (frame_done !== 1'b0) $display("FAIL ar_no_done got %b want 0", frame_done); else n_pass++;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      test_reset();
      test_round_robin();
      test_drain();
      test_b_only();
      test_pause();
      test_hist_ready();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
